// File: rtl/strobe_fifo.sv
// rtl/strobe_fifo.sv - strobe-qualified show-ahead FIFO with level status and sticky errors
module strobe_fifo #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(4'ha),
  parameter int               LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_stb,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             rd_stb,
  input  logic             clr_err,
  output logic [WIDTH-1:0] outp,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level,
  output logic             ovf,
  output logic             udf
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_dly_q, rd_dly_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    level_q, level_d;
  logic             empty_q, full_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] outp_q, outp_d;

  logic push_req, pop_req, push_ok, pop_ok;

  always_comb begin
    push_req   = wr_dly_q & wr_stb;
    pop_req    = rd_dly_q & rd_stb;
    pop_ok     = pop_req & (level_q != '0);
    // A full queue still accepts a write when the head leaves in the same cycle.
    push_ok    = push_req & ((level_q < DEPTH_L) | pop_ok);
    rd_ptr_nxt = rd_ptr_q + AW'(1);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_nxt : rd_ptr_q;
    level_d    = level_q + LW'(push_ok) - LW'(pop_ok);

    outp_d = outp_q;
    if (pop_ok && (level_d != '0)) begin
      outp_d = (level_q == LW'(1)) ? din : mem_q[rd_ptr_nxt];
    end else if (push_ok && (level_q == '0)) begin
      outp_d = din;
    end

    // A new error in the clearing cycle keeps its flag set.
    ovf_d = (ovf_q & ~clr_err) | (push_req & ~push_ok);
    udf_d = (udf_q & ~clr_err) | (pop_req & ~pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_dly_q <= 1'b0;
      rd_dly_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      outp_q   <= RESET_VAL;
    end else begin
      wr_dly_q <= wr_en;
      rd_dly_q <= rd_en;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= (level_d == DEPTH_L);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      outp_q   <= outp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign outp  = outp_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_strobe_fifo.sv
// tb/tb_strobe_fifo.sv - self-checking bench for strobe_fifo
module tb_strobe_fifo;

  localparam int               WIDTH = 4;
  localparam int               DEPTH = 4;
  localparam int               LW    = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RV    = 4'ha;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b1;
  logic             wr_en   = 1'b0;
  logic             wr_stb  = 1'b0;
  logic [WIDTH-1:0] din     = '0;
  logic             rd_en   = 1'b0;
  logic             rd_stb  = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] outp;
  logic             empty, full, ovf, udf;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  strobe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_stb(wr_stb), .din(din),
    .rd_en(rd_en), .rd_stb(rd_stb), .clr_err(clr_err), .outp(outp),
    .empty(empty), .full(full), .level(level), .ovf(ovf), .udf(udf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue plus the two arm registers and sticky flags.
  logic [WIDTH-1:0] m_q[$];
  logic             m_wr_dly, m_rd_dly, m_ovf, m_udf;
  logic [WIDTH-1:0] m_outp;

  typedef struct {
    logic             we, ws;
    logic [WIDTH-1:0] d;
    logic             re, rs, clr;
    logic [WIDTH-1:0] e_outp;
    int               e_lvl;
    logic             e_ovf, e_udf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input logic we, ws, input logic [WIDTH-1:0] d,
                                  input logic re, rs, clr, input logic [WIDTH-1:0] e_outp,
                                  input int e_lvl, input logic e_ovf, e_udf);
    vec_t v;
    v.we = we; v.ws = ws; v.d = d; v.re = re; v.rs = rs; v.clr = clr;
    v.e_outp = e_outp; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_udf = e_udf;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_wr_dly = 1'b0;
    m_rd_dly = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_outp   = RV;
  endfunction

  function automatic void model_step();
    logic push_req, pop_req, push_ok, pop_ok;
    push_req = m_wr_dly & wr_stb;
    pop_req  = m_rd_dly & rd_stb;
    pop_ok   = pop_req && (m_q.size() != 0);
    push_ok  = push_req && ((m_q.size() < DEPTH) || pop_ok);
    if (pop_ok) void'(m_q.pop_front());
    if (push_ok) m_q.push_back(din);
    if (m_q.size() != 0) m_outp = m_q[0];
    m_ovf    = (m_ovf && !clr_err) || (push_req && !push_ok);
    m_udf    = (m_udf && !clr_err) || (pop_req && !pop_ok);
    m_wr_dly = wr_en;
    m_rd_dly = rd_en;
  endfunction

  task automatic check_model(input string tag);
    check({tag, " outp"},  32'(outp),  32'(m_outp));
    check({tag, " level"}, 32'(level), 32'(m_q.size()));
    check({tag, " empty"}, 32'(empty), 32'(m_q.size() == 0));
    check({tag, " full"},  32'(full),  32'(m_q.size() == DEPTH));
    check({tag, " ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, " udf"},   32'(udf),   32'(m_udf));
  endtask

  task automatic cycle(input string tag, input logic we, ws, input logic [WIDTH-1:0] d,
                       input logic re, rs, clr);
    wr_en = we; wr_stb = ws; din = d; rd_en = re; rd_stb = rs; clr_err = clr;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  // Asserts reset between edges and checks the async response before any edge.
  task automatic apply_reset(input string tag);
    wr_en = 0; wr_stb = 0; din = '0; rd_en = 0; rd_stb = 0; clr_err = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, " outp"},  32'(outp),  32'(RV));
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " full"},  32'(full),  32'd0);
    check({tag, " level"}, 32'(level), 32'd0);
    check({tag, " ovf"},   32'(ovf),   32'd0);
    check({tag, " udf"},   32'(udf),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // we ws d  re rs clr | outp lvl ovf udf
    add_vec(1, 0, 0, 0, 0, 0, 4'ha, 0, 0, 0);
    add_vec(1, 1, 1, 0, 0, 0, 4'h1, 1, 0, 0);
    add_vec(1, 1, 2, 0, 0, 0, 4'h1, 2, 0, 0);
    add_vec(1, 1, 3, 0, 0, 0, 4'h1, 3, 0, 0);
    add_vec(1, 1, 4, 0, 0, 0, 4'h1, 4, 0, 0);
    add_vec(0, 1, 9, 0, 0, 0, 4'h1, 4, 1, 0);
    add_vec(0, 0, 0, 1, 0, 1, 4'h1, 4, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 4'h2, 3, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 4'h3, 2, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 4'h4, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 4'h4, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 4'h4, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1, 0, 4'h4, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 4'h4, 0, 0, 0);
    add_vec(1, 0, 0, 1, 0, 0, 4'h4, 0, 0, 0);
    add_vec(0, 1, 5, 0, 1, 0, 4'h5, 1, 0, 1);

    apply_reset("reset");
    foreach (tbl[i]) begin
      cycle($sformatf("vec%0d", i), tbl[i].we, tbl[i].ws, tbl[i].d, tbl[i].re, tbl[i].rs, tbl[i].clr);
      check($sformatf("vec%0d tbl_outp", i),  32'(outp),  32'(tbl[i].e_outp));
      check($sformatf("vec%0d tbl_level", i), 32'(level), 32'(tbl[i].e_lvl));
      check($sformatf("vec%0d tbl_empty", i), 32'(empty), 32'(tbl[i].e_lvl == 0));
      check($sformatf("vec%0d tbl_full", i),  32'(full),  32'(tbl[i].e_lvl == DEPTH));
      check($sformatf("vec%0d tbl_ovf", i),   32'(ovf),   32'(tbl[i].e_ovf));
      check($sformatf("vec%0d tbl_udf", i),   32'(udf),   32'(tbl[i].e_udf));
    end

    // Replace-through on a full queue: 7 enters as 1 leaves, and comes out last.
    apply_reset("rt_reset");
    cycle("rt_arm", 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle("rt_fill", 1, 1, 4'(i), (i == 4), 0, 0);
    cycle("rt_swap", 0, 1, 7, 1, 1, 0);
    check("rt_swap level", 32'(level), 32'd4);
    check("rt_swap outp",  32'(outp),  32'd2);
    check("rt_swap ovf",   32'(ovf),   32'd0);
    begin
      logic [WIDTH-1:0] exp_out [4];
      exp_out[0] = 4'd3; exp_out[1] = 4'd4; exp_out[2] = 4'd7; exp_out[3] = 4'd7;
      for (int i = 0; i < 4; i++) begin
        cycle("rt_drain", 0, 0, 0, 1, 1, 0);
        check($sformatf("rt_drain%0d outp", i), 32'(outp), 32'(exp_out[i]));
      end
      check("rt_drain empty", 32'(empty), 32'd1);
    end

    // Arming: only a strobe exactly one cycle after wr_en pushes.
    apply_reset("arm_reset");
    for (int i = 0; i < 3; i++) cycle("arm_stb_only", 0, 1, 3, 0, 1, 0);
    cycle("arm_pulse", 1, 0, 0, 0, 0, 0);
    cycle("arm_gap", 0, 0, 0, 0, 0, 0);
    cycle("arm_late", 0, 1, 6, 0, 0, 0);
    check("arm_late level", 32'(level), 32'd0);
    check("arm_late ovf",   32'(ovf),   32'd0);
    check("arm_late udf",   32'(udf),   32'd0);
    cycle("arm_pulse2", 1, 0, 0, 0, 0, 0);
    cycle("arm_ontime", 1, 1, 6, 0, 0, 0);
    check("arm_ontime level", 32'(level), 32'd1);
    check("arm_ontime outp",  32'(outp),  32'd6);
    cycle("arm_more", 1, 1, 8, 0, 0, 0);
    cycle("arm_more", 0, 1, 9, 0, 0, 0);
    check("pre_async level", 32'(level), 32'd3);

    // Asynchronous reset with three entries stored.
    apply_reset("async_reset");

    // Randomised run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            ($urandom_range(3) != 0), $urandom_range(1), 4'($urandom),
            ($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
